wm_phase_timer: RTL and testbench

WM_PHASE_TIMER -- requirements
Module: wm_phase_timer

---
 rtl/wm_phase_timer_if.sv | 28 ++
 rtl/wm_phase_timer.sv | 151 +++++++++++++++
 tb/tb_wm_phase_timer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/wm_phase_timer_if.sv
// wm_phase_timer_if: controller <-> phase timer signal bundle.
//   motor_on        controller motor command (wash cycle running)
//   drain_value_on  controller drain-valve command
//   drained         tub-empty sensor
//   cycle_timeout   wash cycle elapsed
//   spin_timeout    spin elapsed
//   busy            timer is counting a run
//   elapsed_ticks   ticks counted in the current run
// master: controller/sensor side. slave: the timer.
interface wm_phase_timer_if;
  logic        motor_on;
  logic        drain_value_on;
  logic        drained;
  logic        cycle_timeout;
  logic        spin_timeout;
  logic        busy;
  logic [15:0] elapsed_ticks;

  modport master (
    output motor_on, drain_value_on, drained,
    input  cycle_timeout, spin_timeout, busy, elapsed_ticks
  );

  modport slave (
    input  motor_on, drain_value_on, drained,
    output cycle_timeout, spin_timeout, busy, elapsed_ticks
  );
endinterface

// File: rtl/wm_phase_timer.sv
// wm_phase_timer: washing-machine wash/spin phase timer.
// A prescaler divides clk into ticks; the wash cycle times out after
// CYCLE_TICKS ticks of motor_on, the spin after SPIN_TICKS ticks of
// drain_value_on (started only when the tub reads drained).
// Ports:
//   clk    single clock, posedge
//   reset  synchronous, active-high
//   pause  (only with WM_TIMER_PAUSE_EN defined) freezes counting in RUN
//   tif    wm_phase_timer_if.slave: commands in, timeouts/busy/ticks out
// Optional feature macro: WM_TIMER_PAUSE_EN.
//
// state    | meaning
// IDLE     | waiting for motor_on, or drain_value_on with drained
// CYC_RUN  | counting the wash cycle
// CYC_DONE | wash cycle elapsed, waiting for motor_on to drop
// SPN_RUN  | counting the spin
// SPN_DONE | spin elapsed, waiting for drain_value_on to drop
module wm_phase_timer #(
  parameter int unsigned PRESCALE    = 100,
  parameter int unsigned CYCLE_TICKS = 600,
  parameter int unsigned SPIN_TICKS  = 300
) (
  input logic clk,
  input logic reset,
`ifdef WM_TIMER_PAUSE_EN
  input logic pause,
`endif
  wm_phase_timer_if.slave tif
);

  localparam logic [15:0] PRE_LAST  = 16'(PRESCALE - 1);
  localparam logic [15:0] CYC_LIMIT = 16'(CYCLE_TICKS);
  localparam logic [15:0] SPN_LIMIT = 16'(SPIN_TICKS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CYC_RUN  = 3'd1,
    CYC_DONE = 3'd2,
    SPN_RUN  = 3'd3,
    SPN_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pre_q, pre_d;
  logic [15:0] elapsed_q, elapsed_d;
  logic        cycle_to_q, cycle_to_d;
  logic        spin_to_q, spin_to_d;

  logic        hold;
  logic        tick;
  logic [15:0] elapsed_inc;

`ifdef WM_TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    elapsed_d   = elapsed_q;
    tick        = (pre_q == PRE_LAST);
    elapsed_inc = elapsed_q + 16'd1;

    case (state_q)
      IDLE: begin
        // Counters sit at zero here, so entering a RUN state starts clean.
        pre_d     = '0;
        elapsed_d = '0;
        if (tif.motor_on) begin
          state_d = CYC_RUN;
        end else if (tif.drain_value_on && tif.drained) begin
          state_d = SPN_RUN;
        end
      end
      CYC_RUN: begin
        // Abort wins over a tick landing on the same edge.
        if (!tif.motor_on) begin
          state_d   = IDLE;
          pre_d     = '0;
          elapsed_d = '0;
        end else if (!hold) begin
          pre_d = tick ? 16'd0 : pre_q + 16'd1;
          if (tick) begin
            elapsed_d = elapsed_inc;
            if (elapsed_inc == CYC_LIMIT) state_d = CYC_DONE;
          end
        end
      end
      CYC_DONE: begin
        if (!tif.motor_on) begin
          state_d   = IDLE;
          pre_d     = '0;
          elapsed_d = '0;
        end
      end
      SPN_RUN: begin
        // drained is only an entry qualifier; once spinning it is ignored.
        if (!tif.drain_value_on) begin
          state_d   = IDLE;
          pre_d     = '0;
          elapsed_d = '0;
        end else if (!hold) begin
          pre_d = tick ? 16'd0 : pre_q + 16'd1;
          if (tick) begin
            elapsed_d = elapsed_inc;
            if (elapsed_inc == SPN_LIMIT) state_d = SPN_DONE;
          end
        end
      end
      SPN_DONE: begin
        if (!tif.drain_value_on) begin
          state_d   = IDLE;
          pre_d     = '0;
          elapsed_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        pre_d     = '0;
        elapsed_d = '0;
      end
    endcase

    cycle_to_d = (state_d == CYC_DONE);
    spin_to_d  = (state_d == SPN_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      elapsed_q  <= '0;
      cycle_to_q <= 1'b0;
      spin_to_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      elapsed_q  <= elapsed_d;
      cycle_to_q <= cycle_to_d;
      spin_to_q  <= spin_to_d;
    end
  end

  assign tif.cycle_timeout = cycle_to_q;
  assign tif.spin_timeout  = spin_to_q;
  assign tif.busy          = (state_q == CYC_RUN) || (state_q == SPN_RUN);
  assign tif.elapsed_ticks = elapsed_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Testbench for wm_phase_timer with PRESCALE=4, CYCLE_TICKS=3, SPIN_TICKS=2.
// The reference model tracks only the active phase and the number of
// counting clocks since that phase began; ticks are clocks/PRESCALE.
module tb_wm_phase_timer;
  localparam int P  = 4;
  localparam int CT = 3;
  localparam int ST = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef WM_TIMER_PAUSE_EN
  logic pause = 1'b0;
`endif

  wm_phase_timer_if bus ();

  wm_phase_timer #(.PRESCALE(P), .CYCLE_TICKS(CT), .SPIN_TICKS(ST)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef WM_TIMER_PAUSE_EN
    .pause (pause),
`endif
    .tif   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 wash counting, 2 wash done, 3 spin counting, 4 spin done.
  int phase = 0;
  int clocks = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic m, input logic d, input logic dr, input logic pz);
    if (r) begin
      phase = 0; clocks = 0;
    end else begin
      case (phase)
        0: begin
          clocks = 0;
          if (m) phase = 1;
          else if (d && dr) phase = 3;
        end
        1: if (!m) phase = 0;
           else if (!pz) begin
             clocks++;
             if (clocks == P * CT) phase = 2;
           end
        2: if (!m) phase = 0;
        3: if (!d) phase = 0;
           else if (!pz) begin
             clocks++;
             if (clocks == P * ST) phase = 4;
           end
        4: if (!d) phase = 0;
        default: phase = 0;
      endcase
      if (phase == 0) clocks = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".cycle_timeout"}, 16'(bus.cycle_timeout), 16'(phase == 2));
    check({tag, ".spin_timeout"},  16'(bus.spin_timeout),  16'(phase == 4));
    check({tag, ".busy"},          16'(bus.busy),          16'(phase == 1 || phase == 3));
    check({tag, ".elapsed"},       bus.elapsed_ticks,      16'((phase == 0) ? 0 : clocks / P));
    check({tag, ".exclusive"},     16'(bus.cycle_timeout & bus.spin_timeout), 16'd0);
  endtask

  task automatic step(input string tag, input logic r, input logic m, input logic d, input logic dr);
    logic pz;
    pz = 1'b0;
`ifdef WM_TIMER_PAUSE_EN
    pz = pause;
`endif
    reset = r;
    bus.motor_on = m;
    bus.drain_value_on = d;
    bus.drained = dr;
    @(posedge clk);
    model_edge(r, m, d, dr, pz);
    #1;
    compare_all(tag);
  endtask

  logic rm, rd, rdr, rr;

  initial begin
    bus.motor_on = 1'b0;
    bus.drain_value_on = 1'b0;
    bus.drained = 1'b0;

    // Reset state
    step("reset", 1, 0, 0, 0);
    step("reset2", 1, 1, 1, 1);
    check("reset.elapsed0", bus.elapsed_ticks, 16'd0);

    // Wash cycle timeout: 12 clocks after entry, clears on motor drop
    step("cyc_entry", 0, 1, 0, 0);
    for (int i = 1; i <= 12; i++) step("cyc_run", 0, 1, 0, 0);
    check("cyc_timeout_at12", 16'(bus.cycle_timeout), 16'd1);
    check("cyc_done_elapsed", bus.elapsed_ticks, 16'(CT));
    step("cyc_hold_done", 0, 1, 0, 0);
    step("cyc_exit", 0, 0, 0, 0);
    check("cyc_exit_to", 16'(bus.cycle_timeout), 16'd0);

    // Spin timeout with drained dropping mid-run
    step("spn_entry", 0, 0, 1, 1);
    for (int i = 1; i <= 8; i++) step("spn_run", 0, 0, 1, (i < 5) ? 1'b1 : 1'b0);
    check("spn_timeout_at8", 16'(bus.spin_timeout), 16'd1);
    step("spn_exit", 0, 0, 0, 0);

    // Wash abort at clock 7 then full restart
    step("abort_entry", 0, 1, 0, 0);
    for (int i = 1; i < 7; i++) step("abort_run", 0, 1, 0, 0);
    step("abort_drop", 0, 0, 0, 0);
    check("abort_elapsed", bus.elapsed_ticks, 16'd0);
    step("restart_entry", 0, 1, 0, 0);
    for (int i = 1; i <= 12; i++) step("restart_run", 0, 1, 0, 0);
    check("restart_timeout", 16'(bus.cycle_timeout), 16'd1);
    step("restart_exit", 0, 0, 0, 0);

    // Reset mid-run with elapsed_ticks=2
    step("rst_entry", 0, 1, 0, 0);
    for (int i = 1; i <= 8; i++) step("rst_run", 0, 1, 0, 0);
    check("rst_pre_elapsed", bus.elapsed_ticks, 16'd2);
    step("rst_mid", 1, 1, 0, 0);
    step("rst_hold", 1, 1, 0, 0);
    check("rst_busy", 16'(bus.busy), 16'd0);
    step("rst_exit", 0, 0, 0, 0);

    // Priority and drain qualifier
    step("prio", 0, 1, 1, 1);
    check("prio_busy", 16'(bus.busy), 16'd1);
    step("prio_exit", 0, 0, 0, 0);
    step("undrained", 0, 0, 1, 0);
    step("undrained2", 0, 0, 1, 0);
    check("undrained_busy", 16'(bus.busy), 16'd0);
    step("undrained_exit", 0, 0, 0, 0);

`ifdef WM_TIMER_PAUSE_EN
    // Pause for 5 clocks stretches the wash to 17 clocks
    step("pz_entry", 0, 1, 0, 0);
    for (int i = 1; i <= 17; i++) begin
      pause = (i >= 3 && i < 8);
      step("pz_run", 0, 1, 0, 0);
    end
    pause = 1'b0;
    check("pz_timeout_at17", 16'(bus.cycle_timeout), 16'd1);
    step("pz_exit", 0, 0, 0, 0);
`endif

    // Randomized commands with long holds so timeouts are reached
    rm = 0; rd = 0; rdr = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) rm = ~rm;
      if ($urandom_range(11) == 0) rd = ~rd;
      if ($urandom_range(3) == 0) rdr = ~rdr;
      rr = ($urandom_range(199) == 0);
`ifdef WM_TIMER_PAUSE_EN
      pause = ($urandom_range(7) == 0);
`endif
      step("rand", rr, rm, rd, rdr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
